sipo_frame_ctrl: RTL
====================

// Module: sipo_frame_ctrl
// PURPOSE
//  Controls capture of framed serial data into WIDTH-bit parallel words, for an
//  external serial source (sclk/frame_n/sdata). It synchronises the inputs, detects
//  sclk rising edges, shifts bits MSB-first and counts them. Each completed word is
//  published through a valid/ready handshake to the downstream datapath.
//  Overruns and truncated frames are flagged.
// PARAMETERS
//  WIDTH     16  bits per word (>=2)
//  SYNC_LEN   2  synchroniser flops on sclk/frame_n/sdata (>=2)
// PORTS
//  clk         in   1      system clock (100 MHz)
//  rst         in   1      asynchronous reset, active-low
//  sclk        in   1      serial bit clock, async, data valid on rising edge
//  frame_n     in   1      frame enable, async, active-low
//  sdata       in   1      serial data, async
//  word_out    out  WIDTH  captured word, held stable while word_valid=1
//  word_valid  out  1      word_out holds an unconsumed word
//  word_ready  in   1      downstream accepts; transfer when valid&ready at clk rise
//  busy        out  1      FSM not in IDLE
//  frame_err   out  1      1-cycle pulse: frame ended with partial word (bit_cnt!=0)
//  overrun     out  1      sticky: completed word dropped; cleared only by rst
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, bit_cnt=0, shift reg=0, word_out=0,
//    word_valid=0, frame_err=0, overrun=0, all sync flops=idle level (sclk 0, frame_n 1).
//  - All async inputs pass through SYNC_LEN flops; sclk gets one extra flop for edge
//    detect: sclk_rise = sclk_s & ~sclk_d. sdata is sampled from its synced copy.
//  - FSM:
//    IDLE  : frame_n_s=1 -> stay; frame_n_s=0 -> SHIFT, bit_cnt=0.
//    SHIFT : on sclk_rise: sr <= {sr[WIDTH-2:0], sdata_s}, bit_cnt++.
//            when sclk_rise and bit_cnt==WIDTH-1: word complete, bit_cnt wraps to 0,
//            stay in SHIFT (back-to-back words within one frame allowed).
//            frame_n_s=1 -> FLUSH (an sclk_rise in the same cycle is ignored).
//    FLUSH : one cycle; frame_err=1 if bit_cnt!=0; clear bit_cnt and sr; -> IDLE.
//  - Word completion: new word = {sr[WIDTH-2:0], sdata_s}.
//    If word_valid=0, or word_valid&word_ready in the same cycle: load word_out,
//    word_valid=1.
//    Else: drop the word, set overrun, keep word_out unchanged.
//  - Latency: word_valid rises on the clk edge that samples the final sclk_rise, i.e.
//    SYNC_LEN+1 clk after the last external sclk edge.
//  - Handshake: word_valid&word_ready with no completion -> word_valid=0 next cycle.
//    word_out never changes while word_valid=1 except at a same-cycle accept+reload.
//  - Bits shifted while frame_n_s=1 are ignored (no shift, no count).
//  - Reset mid-word discards all state; first frame after reset starts at bit 0.
//  - busy=1 in SHIFT and FLUSH.
//  - sclk frequency must be <= clk/4 (min 2 clk high, 2 clk low); faster is unsupported.
// TESTING
//  1 Frame, 16 bits 0xA5C3 MSB-first, word_ready=1 -> one word_valid pulse,
//    word_out=0xA5C3, frame_err=0, overrun=0.
//  2 Frame, 32 bits 0x1234,0xBEEF, ready=1 -> two transfers in order,
//    bit_cnt wraps, no errors.
//  3 Frame, 32 bits 0x1111,0x2222, ready=0 throughout -> word_out=0x1111 held,
//    overrun=1; raise ready -> single transfer of 0x1111.
//  4 Frame ends after 9 bits -> frame_err pulses 1 cycle in FLUSH, no word_valid;
//    next 16-bit frame 0x00FF -> word_out=0x00FF.
//  5 rst=0 asserted after 8 bits -> all outputs 0 immediately;
//    next frame 0x8001 captured correctly.
//  6 Word completes in the same cycle as the accept of the previous word
//    -> new word loaded, word_valid stays 1, no overrun.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel capture: synchronises sclk/frame_n/sdata, shifts bits MSB-first
// and publishes each completed WIDTH-bit word through a valid/ready handshake.
module sipo_frame_ctrl #(
  parameter int WIDTH    = 16,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             frame_n,
  input  logic             sdata,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_LEN-1:0] sclk_sync_q, frame_sync_q, sdata_sync_q;
  logic               sclk_dly_q;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               sclk_s, frame_n_s, sdata_s, sclk_rise;
  logic               complete;

  assign sclk_s    = sclk_sync_q[SYNC_LEN-1];
  assign frame_n_s = frame_sync_q[SYNC_LEN-1];
  assign sdata_s   = sdata_sync_q[SYNC_LEN-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  // Synchronisers reset to the idle line levels so reset never looks like a frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q  <= '0;
      frame_sync_q <= '1;
      sdata_sync_q <= '0;
      sclk_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_LEN-2:0], sclk};
      frame_sync_q <= {frame_sync_q[SYNC_LEN-2:0], frame_n};
      sdata_sync_q <= {sdata_sync_q[SYNC_LEN-2:0], sdata};
      sclk_dly_q   <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // End of frame wins over a coincident sclk edge
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    complete  = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!frame_n_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (frame_n_s) begin
          state_d = FLUSH;
        end else if (sclk_rise) begin
          sr_d = {sr_q[WIDTH-2:0], sdata_s};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            complete  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        frame_err = (bit_cnt_q != '0);
        bit_cnt_d = '0;
        sr_d      = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed word may reload the output only if the slot is empty or being drained now
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
